circle_dispatch: RTL

CIRCLE_DISPATCH -- requirements
Module: circle_dispatch

---
 rtl/circle_pkg.sv | 36 +++
 rtl/circle_fifo.sv | 69 ++++++
 rtl/circle_dispatch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/circle_pkg.sv
// ============================================================================
// circle_pkg : shared opcodes, command-word field map and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package circle_pkg;

    localparam int OPC_LSB = 26;
    localparam int OPC_W   = 6;
    localparam int RAD_LSB = 18;
    localparam int RAD_W   = 8;
    localparam int CY_LSB  = 9;
    localparam int CX_LSB  = 0;
    localparam int COORD_W = 9;

    localparam logic [OPC_W-1:0] OP_CLEAR   = 6'd0;
    localparam logic [OPC_W-1:0] OP_ENQUEUE = 6'd1;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_TOTAL  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DISPATCH   = 2'd1,
        ST_CLEAR_WAIT = 2'd2,
        ST_CLEAR      = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/circle_fifo.sv
// ============================================================================
// circle_fifo : synchronous first-word-fall-through command queue
// Rev 1.0
// ============================================================================
`default_nettype none

module circle_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   OCC_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   OCC_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == OCC_MAX);
    assign empty   = (occ == '0);
    assign count   = occ;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by occ.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/circle_dispatch.sv
// ============================================================================
// circle_dispatch : Avalon-MM command queue feeding round-robin plot engines
// Rev 1.0
// ============================================================================
`default_nettype none

module circle_dispatch
    import circle_pkg::*;
#(
    parameter int CIRCLES = 3,
    parameter int DATAW   = 18,
    parameter int QDEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               write,
    input  logic [31:0]        writedata,
    input  logic               read,
    input  logic [1:0]         address,
    output logic [31:0]        readdata,
    output logic               readdatavalid,
    output logic               waitrequest,
    output logic [CIRCLES-1:0] eng_start,
    output logic [8:0]         eng_cx,
    output logic [8:0]         eng_cy,
    output logic [7:0]         eng_radius,
    input  logic [CIRCLES-1:0] eng_busy,
    output logic               eng_clear,
    output logic               irq_done
);

    localparam int HALF    = DATAW / 2;
    localparam int ENTRY_W = RAD_W + DATAW;
    localparam int IDXW    = (CIRCLES > 1) ? $clog2(CIRCLES) : 1;
    localparam int CNTW    = $clog2(QDEPTH) + 1;
    localparam int BM_W    = (CIRCLES < 3) ? CIRCLES : 3;

    state_t             state;
    logic [CIRCLES-1:0] pending;
    logic [CIRCLES-1:0] avail;
    logic [CIRCLES-1:0] grant;
    logic [IDXW-1:0]    rr_ptr;
    logic [IDXW-1:0]    grant_idx;
    logic [IDXW-1:0]    cand_idx;
    logic [IDXW-1:0]    next_ptr;
    logic               grant_valid;
    int                 cand;

    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNTW-1:0]    fifo_count;

    logic [OPC_W-1:0]   opcode;
    logic               accept_wr;
    logic               accept_rd;
    logic               clear_cmd;
    logic               enq_cmd;
    logic               push;
    logic               dispatching;
    logic               overflow;
    logic [15:0]        disp_total;
    logic [31:0]        status_word;
    logic [31:0]        rd_mux;
    logic               irq_cond;

    assign waitrequest = (state == ST_CLEAR_WAIT) || (state == ST_CLEAR);
    assign opcode      = writedata[OPC_LSB +: OPC_W];
    assign accept_wr   = write && !waitrequest;
    assign accept_rd   = read && !waitrequest;
    assign clear_cmd   = accept_wr && (opcode == OP_CLEAR);
    assign enq_cmd     = accept_wr && (opcode == OP_ENQUEUE);
    assign push        = enq_cmd && !fifo_full;
    assign push_entry  = {writedata[RAD_LSB +: RAD_W],
                          writedata[CY_LSB +: HALF],
                          writedata[CX_LSB +: HALF]};

    circle_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear_cmd),
        .push    (push),
        .pop     (dispatching),
        .din     (push_entry),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // An engine started last cycle has not raised busy yet, so pending masks it.
    always_comb begin
        avail       = ~eng_busy & ~pending;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < CIRCLES; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= CIRCLES) cand = cand - CIRCLES;
            cand_idx = IDXW'(cand);
            if (!grant_valid && avail[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        grant    = grant_valid ? (CIRCLES'(1) << grant_idx) : '0;
        next_ptr = (grant_idx == IDXW'(CIRCLES - 1)) ? '0 : grant_idx + IDXW'(1);
    end

    assign dispatching = (state == ST_DISPATCH) && !fifo_empty && grant_valid;
    assign eng_start   = dispatching ? grant : '0;
    assign eng_cx      = dispatching ? COORD_W'(head[HALF-1:0]) : '0;
    assign eng_cy      = dispatching ? COORD_W'(head[DATAW-1:HALF]) : '0;
    assign eng_radius  = dispatching ? head[ENTRY_W-1:DATAW] : '0;

    always_comb begin
        status_word                = '0;
        status_word[31:30]         = state;
        status_word[15:8]          = 8'(fifo_count);
        status_word[5 +: BM_W]     = eng_busy[BM_W-1:0];
        status_word[2]             = overflow;
        status_word[1]             = fifo_full;
        status_word[0]             = fifo_empty;
        case (address)
            ADDR_STATUS: rd_mux = status_word;
            ADDR_TOTAL:  rd_mux = {16'd0, disp_total};
            default:     rd_mux = '0;
        endcase
    end

    assign irq_cond = ((state == ST_IDLE) || (state == ST_DISPATCH)) && !clear_cmd
                      && fifo_empty && !push && !dispatching
                      && (eng_busy == '0) && (pending == '0) && (disp_total != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pending       <= '0;
            rr_ptr        <= '0;
            overflow      <= 1'b0;
            disp_total    <= '0;
            eng_clear     <= 1'b0;
            irq_done      <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            pending       <= eng_start;
            eng_clear     <= 1'b0;
            irq_done      <= irq_cond;
            readdatavalid <= accept_rd;
            readdata      <= accept_rd ? rd_mux : '0;

            if (dispatching) begin
                rr_ptr     <= next_ptr;
                disp_total <= sat_inc16(disp_total);
            end
            if (enq_cmd && fifo_full) overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty || push) state <= ST_DISPATCH;
                end
                ST_DISPATCH: begin
                    if (fifo_empty && !push) state <= ST_IDLE;
                end
                ST_CLEAR_WAIT: begin
                    if ((eng_busy == '0) && (pending == '0)) begin
                        state     <= ST_CLEAR;
                        eng_clear <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state      <= ST_IDLE;
                    overflow   <= 1'b0;
                    disp_total <= '0;
                end
                default: state <= ST_IDLE;
            endcase

            // A clear is only accepted outside the clear states (waitrequest low).
            if (clear_cmd) state <= ST_CLEAR_WAIT;
        end
    end

endmodule

`default_nettype wire
